// File: rtl/mips_ctrl_pkg.sv
// Shared opcode, func, ALU and state encodings for the multi-cycle MIPS controller.
// Feature macro used by the controller: MULTICYCLE_ILLEGAL_TRAP_EN.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R     = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SEQ   = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_BGT   = 6'd24;
  localparam logic [5:0] OP_BGTE  = 6'd25;
  localparam logic [5:0] OP_BLE   = 6'd26;
  localparam logic [5:0] OP_BLEQ  = 6'd27;
  localparam logic [5:0] OP_BLEU  = 6'd28;
  localparam logic [5:0] OP_BGTU  = 6'd29;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_HALT  = 6'd63;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_SLLV  = 6'd4;
  localparam logic [5:0] F_SRLV  = 6'd6;
  localparam logic [5:0] F_SRAV  = 6'd7;
  localparam logic [5:0] F_JR    = 6'd8;
  localparam logic [5:0] F_MADD  = 6'd28;
  localparam logic [5:0] F_MADDU = 6'd29;
  localparam logic [5:0] F_MUL   = 6'd30;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_ADDU  = 6'd33;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SUBU  = 6'd35;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  localparam logic [5:0] ALU_ADD   = 6'd0;
  localparam logic [5:0] ALU_ADDU  = 6'd1;
  localparam logic [5:0] ALU_SUB   = 6'd2;
  localparam logic [5:0] ALU_SUBU  = 6'd3;
  localparam logic [5:0] ALU_AND   = 6'd4;
  localparam logic [5:0] ALU_OR    = 6'd5;
  localparam logic [5:0] ALU_MUL   = 6'd6;
  localparam logic [5:0] ALU_MADD  = 6'd7;
  localparam logic [5:0] ALU_MADDU = 6'd8;
  localparam logic [5:0] ALU_XOR   = 6'd9;
  localparam logic [5:0] ALU_NOR   = 6'd10;
  localparam logic [5:0] ALU_SLT   = 6'd11;
  localparam logic [5:0] ALU_SLTU  = 6'd12;
  localparam logic [5:0] ALU_SLL   = 6'd13;
  localparam logic [5:0] ALU_SRL   = 6'd14;
  localparam logic [5:0] ALU_SLA   = 6'd15;
  localparam logic [5:0] ALU_EQ    = 6'd16;
  localparam logic [5:0] ALU_NE    = 6'd17;
  localparam logic [5:0] ALU_GT    = 6'd18;
  localparam logic [5:0] ALU_GE    = 6'd19;
  localparam logic [5:0] ALU_LEQ   = 6'd20;
  localparam logic [5:0] ALU_LEU   = 6'd21;
  localparam logic [5:0] ALU_GTU   = 6'd22;
  localparam logic [5:0] ALU_LUI   = 6'd23;
  localparam logic [5:0] ALU_JR    = 6'd24;

  localparam logic [1:0] SRC_RT    = 2'd0;
  localparam logic [1:0] SRC_IMM   = 2'd1;
  localparam logic [1:0] SRC_SHAMT = 2'd2;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_REG = 2'd3;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  typedef enum logic [3:0] {
    CL_ALU, CL_MUL, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JUMP, CL_JAL, CL_JR, CL_HALT, CL_ILL
  } cls_e;

endpackage

// File: rtl/mips_instr_decoder.sv
// Combinational opcode/func decode into instruction class and datapath selects.
// Unknown opcodes decode to CL_ILL; unknown R-type funcs decode as ADD with illegal set.
module mips_instr_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output cls_e       cls,
  output logic [5:0] alu_op,
  output logic [1:0] alu_src,
  output logic [1:0] reg_dst,
  output logic       illegal
);

  always_comb begin
    cls     = CL_ALU;
    alu_op  = ALU_ADD;
    alu_src = SRC_IMM;
    reg_dst = DST_RT;
    illegal = 1'b0;
    unique case (opcode)
      OP_R: begin
        reg_dst = DST_RD;
        alu_src = SRC_RT;
        case (func)
          F_ADD:   alu_op = ALU_ADD;
          F_ADDU:  alu_op = ALU_ADDU;
          F_SUB:   alu_op = ALU_SUB;
          F_SUBU:  alu_op = ALU_SUBU;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_XOR:   alu_op = ALU_XOR;
          F_NOR:   alu_op = ALU_NOR;
          F_SLT:   alu_op = ALU_SLT;
          F_SLTU:  alu_op = ALU_SLTU;
          F_SLLV:  alu_op = ALU_SLL;
          F_SRLV:  alu_op = ALU_SRL;
          F_SRAV:  alu_op = ALU_SLA;
          F_SLL:   begin alu_op = ALU_SLL; alu_src = SRC_SHAMT; end
          F_SRL:   begin alu_op = ALU_SRL; alu_src = SRC_SHAMT; end
          F_SRA:   begin alu_op = ALU_SLA; alu_src = SRC_SHAMT; end
          F_JR:    begin cls = CL_JR;  alu_op = ALU_JR;    end
          F_MUL:   begin cls = CL_MUL; alu_op = ALU_MUL;   end
          F_MADD:  begin cls = CL_MUL; alu_op = ALU_MADD;  end
          F_MADDU: begin cls = CL_MUL; alu_op = ALU_MADDU; end
          default: illegal = 1'b1;
        endcase
      end
      OP_J:     cls = CL_JUMP;
      OP_JAL:   begin cls = CL_JAL; reg_dst = DST_RA; end
      OP_BEQ:   begin cls = CL_BRANCH; alu_src = SRC_RT; alu_op = ALU_EQ;  end
      OP_BNE:   begin cls = CL_BRANCH; alu_src = SRC_RT; alu_op = ALU_NE;  end
      OP_BGT:   begin cls = CL_BRANCH; alu_src = SRC_RT; alu_op = ALU_GT;  end
      OP_BGTE:  begin cls = CL_BRANCH; alu_src = SRC_RT; alu_op = ALU_GE;  end
      OP_BLE:   begin cls = CL_BRANCH; alu_src = SRC_RT; alu_op = ALU_SLT; end
      OP_BLEQ:  begin cls = CL_BRANCH; alu_src = SRC_RT; alu_op = ALU_LEQ; end
      OP_BLEU:  begin cls = CL_BRANCH; alu_src = SRC_RT; alu_op = ALU_LEU; end
      OP_BGTU:  begin cls = CL_BRANCH; alu_src = SRC_RT; alu_op = ALU_GTU; end
      OP_ADDI:  alu_op = ALU_ADD;
      OP_ADDIU: alu_op = ALU_ADDU;
      OP_SLTI:  alu_op = ALU_SLT;
      OP_SEQ:   alu_op = ALU_EQ;
      OP_ANDI:  alu_op = ALU_AND;
      OP_ORI:   alu_op = ALU_OR;
      OP_XORI:  alu_op = ALU_XOR;
      OP_LUI:   alu_op = ALU_LUI;
      OP_LW:    cls = CL_LOAD;
      OP_SW:    cls = CL_STORE;
      OP_HALT:  cls = CL_HALT;
      default:  begin cls = CL_ILL; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with wait-stated memory.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to halt with illegal=1 on undefined instructions.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int ALU_CTRL_W  = 6,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            func,
  input  logic                  mem_ready,
  input  logic                  branch_taken,
  output logic [2:0]            state,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  ir_write,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic [1:0]            reg_dst,
  output logic [1:0]            alu_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  done,
  output logic                  illegal
);

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY - 1);

  logic [2:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cls_e             cls_q, dec_cls;
  logic [5:0]       alu_q, dec_alu;
  logic [1:0]       src_q, dec_src;
  logic [1:0]       dst_q, dec_dst;
  logic             ill_q, dec_ill;
  logic             trap;

  mips_instr_decoder u_dec (
    .opcode  (opcode),
    .func    (func),
    .cls     (dec_cls),
    .alu_op  (dec_alu),
    .alu_src (dec_src),
    .reg_dst (dec_dst),
    .illegal (dec_ill)
  );

  assign trap = TRAP && dec_ill;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      S_FETCH: if (mem_ready) st_d = S_DECODE;
      S_DECODE: begin
        st_d = S_EXEC;
        if (dec_cls == CL_HALT || trap)
          st_d = S_HALT;
        else if (dec_cls inside {CL_JUMP, CL_JAL, CL_ILL})
          st_d = S_FETCH;
      end
      S_EXEC: begin
        cnt_d = '0;
        if (cls_q == CL_MUL && cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (cls_q inside {CL_BRANCH, CL_JR}) begin
          st_d = S_FETCH;
        end else if (cls_q inside {CL_LOAD, CL_STORE}) begin
          st_d = S_MEM;
        end else begin
          st_d = S_WB;
        end
      end
      S_MEM: if (mem_ready) st_d = (cls_q == CL_STORE) ? S_FETCH : S_WB;
      S_WB:   st_d = S_FETCH;
      S_HALT: st_d = S_HALT;
      default: st_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= S_FETCH;
      cnt_q <= '0;
      cls_q <= CL_ALU;
      alu_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      ill_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (st_q == S_DECODE) begin
        cls_q <= dec_cls;
        alu_q <= dec_alu;
        src_q <= dec_src;
        dst_q <= dec_dst;
        ill_q <= trap;
      end
    end
  end

  // Gated by rst so nothing reaches the datapath while reset is held.
  always_comb begin
    state       = '0;
    pc_write    = 1'b0;
    pc_src      = PC_SEQ;
    ir_write    = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = DST_RT;
    alu_src     = SRC_RT;
    alu_control = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    if (!rst) begin
      state   = st_q;
      illegal = ill_q;
      unique case (st_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: begin
          if (dec_cls inside {CL_JUMP, CL_JAL}) begin
            pc_write = 1'b1;
            pc_src   = PC_JMP;
          end
          if (dec_cls == CL_JAL) begin
            reg_write = 1'b1;
            reg_dst   = dec_dst;
          end
        end
        S_EXEC: begin
          alu_control = ALU_CTRL_W'(alu_q);
          alu_src     = src_q;
          if (cls_q == CL_BRANCH) begin
            pc_write = branch_taken;
            pc_src   = PC_BR;
          end else if (cls_q == CL_JR) begin
            pc_write = 1'b1;
            pc_src   = PC_REG;
          end
        end
        S_MEM: begin
          mem_req   = 1'b1;
          mem_write = (cls_q == CL_STORE);
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = dst_q;
          mem_to_reg = (cls_q == CL_LOAD);
        end
        S_HALT: done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm (MUL_LATENCY=3 and MUL_LATENCY=1).
// Expected per-cycle output vectors are queued by the stimulus and checked by a monitor.
module tb_multicycle_control_fsm;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       mreq;
    logic       mwr;
    logic       m2r;
    logic       rw;
    logic [1:0] dst;
    logic [1:0] src;
    logic [5:0] alu;
    logic       done;
    logic       ill;
  } vec_t;

  typedef struct {
    vec_t  v;
    string tag;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic       mem_ready = 1'b1;
  logic       branch_taken = 1'b0;

  logic [2:0] st0, st1;
  logic       pcw0, pcw1, irw0, irw1, mreq0, mreq1, mwr0, mwr1;
  logic       m2r0, m2r1, rw0, rw1, done0, done1, ill0, ill1;
  logic [1:0] pcs0, pcs1, dst0, dst1, src0, src1;
  logic [5:0] alu0, alu1;

  vec_t  act0, act1;
  item_t q0[$];
  item_t q1[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MUL_LATENCY(3), .ALU_CTRL_W(6), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .state(st0), .pc_write(pcw0), .pc_src(pcs0), .ir_write(irw0),
    .mem_req(mreq0), .mem_write(mwr0), .mem_to_reg(m2r0),
    .reg_write(rw0), .reg_dst(dst0), .alu_src(src0),
    .alu_control(alu0), .done(done0), .illegal(ill0)
  );

  multicycle_control_fsm #(.MUL_LATENCY(1), .ALU_CTRL_W(6), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .state(st1), .pc_write(pcw1), .pc_src(pcs1), .ir_write(irw1),
    .mem_req(mreq1), .mem_write(mwr1), .mem_to_reg(m2r1),
    .reg_write(rw1), .reg_dst(dst1), .alu_src(src1),
    .alu_control(alu1), .done(done1), .illegal(ill1)
  );

  assign act0 = {st0, pcw0, pcs0, irw0, mreq0, mwr0, m2r0, rw0,
                 dst0, src0, alu0, done0, ill0};
  assign act1 = {st1, pcw1, pcs1, irw1, mreq1, mwr1, m2r1, rw1,
                 dst1, src1, alu1, done1, ill1};

  // Monitor: one queued expectation per DUT per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    item_t it;
    if (q0.size() > 0) begin
      it = q0.pop_front();
      checks++;
      if (act0 !== it.v) begin
        errors++;
        $display("FAIL %s lat3 t=%0t got %h want %h", it.tag, $time, act0, it.v);
      end
    end
    if (q1.size() > 0) begin
      it = q1.pop_front();
      checks++;
      if (act1 !== it.v) begin
        errors++;
        $display("FAIL %s lat1 t=%0t got %h want %h", it.tag, $time, act1, it.v);
      end
    end
  end

  function automatic vec_t vs(input logic [2:0] s);
    vec_t v = '0;
    v.st = s;
    return v;
  endfunction

  function automatic vec_t vf(input bit rdy);
    vec_t v = vs(3'd0);
    v.mreq = 1'b1;
    v.irw  = rdy;
    v.pcw  = rdy;
    return v;
  endfunction

  function automatic vec_t ve(input logic [5:0] a, input logic [1:0] s);
    vec_t v = vs(3'd2);
    v.alu = a;
    v.src = s;
    return v;
  endfunction

  function automatic vec_t vm(input bit wr);
    vec_t v = vs(3'd3);
    v.mreq = 1'b1;
    v.mwr  = wr;
    return v;
  endfunction

  function automatic vec_t vw(input logic [1:0] d, input bit m);
    vec_t v = vs(3'd4);
    v.rw  = 1'b1;
    v.dst = d;
    v.m2r = m;
    return v;
  endfunction

  function automatic vec_t vh(input bit il);
    vec_t v = vs(3'd5);
    v.done = 1'b1;
    v.ill  = il;
    return v;
  endfunction

  task automatic push2(input vec_t e0, input vec_t e1, input bit c0,
                       input bit c1, input string tag);
    item_t it;
    it.tag = tag;
    if (c0) begin it.v = e0; q0.push_back(it); end
    if (c1) begin it.v = e1; q1.push_back(it); end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input vec_t e, input string tag);
    push2(e, e, 1'b1, 1'b1, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc('0, "rst_hold");
    cyc('0, "rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    vec_t t;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // ADD: 4 cycles, write only in WB
    opcode = 6'd0; func = 6'd32; mem_ready = 1'b1;
    cyc(vf(1), "add_fetch");
    cyc(vs(3'd1), "add_decode");
    cyc(ve(6'd0, 2'd0), "add_exec");
    cyc(vw(2'd1, 1'b0), "add_wb");
    do_reset();

    // LW with two wait states in FETCH and MEM
    opcode = 6'd35; func = 6'd0; mem_ready = 1'b0;
    cyc(vf(0), "lw_fetch_w1");
    cyc(vf(0), "lw_fetch_w2");
    mem_ready = 1'b1;
    cyc(vf(1), "lw_fetch_rdy");
    cyc(vs(3'd1), "lw_decode");
    cyc(ve(6'd0, 2'd1), "lw_exec");
    mem_ready = 1'b0;
    cyc(vm(0), "lw_mem_w1");
    cyc(vm(0), "lw_mem_w2");
    mem_ready = 1'b1;
    cyc(vm(0), "lw_mem_rdy");
    cyc(vw(2'd0, 1'b1), "lw_wb");
    do_reset();

    // MUL: 3 EXEC cycles at latency 3, 1 at latency 1
    opcode = 6'd0; func = 6'd30; mem_ready = 1'b1;
    cyc(vf(1), "mul_fetch");
    cyc(vs(3'd1), "mul_decode");
    cyc(ve(6'd6, 2'd0), "mul_exec1");
    push2(ve(6'd6, 2'd0), vw(2'd1, 1'b0), 1'b1, 1'b1, "mul_exec2_or_wb");
    push2(ve(6'd6, 2'd0), '0, 1'b1, 1'b0, "mul_exec3");
    push2(vw(2'd1, 1'b0), '0, 1'b1, 1'b0, "mul_wb");
    do_reset();

    // BEQ taken
    opcode = 6'd4; func = 6'd0; branch_taken = 1'b1;
    cyc(vf(1), "beqt_fetch");
    cyc(vs(3'd1), "beqt_decode");
    t = ve(6'd16, 2'd0); t.pcw = 1'b1; t.pcs = 2'd1;
    cyc(t, "beqt_exec");
    cyc(vf(1), "beqt_refetch");
    do_reset();

    // BEQ not taken
    branch_taken = 1'b0;
    cyc(vf(1), "beqn_fetch");
    cyc(vs(3'd1), "beqn_decode");
    t = ve(6'd16, 2'd0); t.pcs = 2'd1;
    cyc(t, "beqn_exec");
    cyc(vf(1), "beqn_refetch");
    do_reset();

    // J and JAL complete in DECODE
    opcode = 6'd2;
    cyc(vf(1), "j_fetch");
    t = vs(3'd1); t.pcw = 1'b1; t.pcs = 2'd2;
    cyc(t, "j_decode");
    cyc(vf(1), "j_refetch");
    do_reset();
    opcode = 6'd3;
    cyc(vf(1), "jal_fetch");
    t = vs(3'd1); t.pcw = 1'b1; t.pcs = 2'd2; t.rw = 1'b1; t.dst = 2'd2;
    cyc(t, "jal_decode");
    cyc(vf(1), "jal_refetch");
    do_reset();

    // JR
    opcode = 6'd0; func = 6'd8;
    cyc(vf(1), "jr_fetch");
    cyc(vs(3'd1), "jr_decode");
    t = ve(6'd24, 2'd0); t.pcw = 1'b1; t.pcs = 2'd3;
    cyc(t, "jr_exec");
    cyc(vf(1), "jr_refetch");
    do_reset();

    // SW with one MEM wait state
    opcode = 6'd43;
    cyc(vf(1), "sw_fetch");
    cyc(vs(3'd1), "sw_decode");
    cyc(ve(6'd0, 2'd1), "sw_exec");
    mem_ready = 1'b0;
    cyc(vm(1), "sw_mem_w");
    mem_ready = 1'b1;
    cyc(vm(1), "sw_mem_rdy");
    cyc(vf(1), "sw_refetch");
    do_reset();

    // SLL uses shamt
    opcode = 6'd0; func = 6'd0;
    cyc(vf(1), "sll_fetch");
    cyc(vs(3'd1), "sll_decode");
    cyc(ve(6'd13, 2'd2), "sll_exec");
    cyc(vw(2'd1, 1'b0), "sll_wb");
    do_reset();

    // HALT is absorbing
    opcode = 6'd63;
    cyc(vf(1), "halt_fetch");
    cyc(vs(3'd1), "halt_decode");
    for (int i = 0; i < 11; i++) cyc(vh(1'b0), "halt_hold");
    do_reset();

    // Reset asserted while waiting in MEM
    opcode = 6'd35;
    cyc(vf(1), "rstmem_fetch");
    cyc(vs(3'd1), "rstmem_decode");
    cyc(ve(6'd0, 2'd1), "rstmem_exec");
    mem_ready = 1'b0;
    cyc(vm(0), "rstmem_mem");
    rst = 1'b1;
    cyc('0, "rstmem_rst");
    rst = 1'b0; mem_ready = 1'b1;
    cyc(vf(1), "rstmem_restart");
    cyc(vs(3'd1), "rstmem_decode2");
    do_reset();

    // Undefined opcode
    opcode = 6'd1;
    cyc(vf(1), "ill_op_fetch");
    cyc(vs(3'd1), "ill_op_decode");
    if (TRAP) begin
      for (int i = 0; i < 3; i++) cyc(vh(1'b1), "ill_op_halt");
    end else begin
      cyc(vf(1), "ill_op_nop_refetch");
    end
    do_reset();

    // Undefined R-type func
    opcode = 6'd0; func = 6'd63;
    cyc(vf(1), "ill_fn_fetch");
    cyc(vs(3'd1), "ill_fn_decode");
    if (TRAP) begin
      cyc(vh(1'b1), "ill_fn_halt");
      cyc(vh(1'b1), "ill_fn_halt2");
    end else begin
      cyc(ve(6'd0, 2'd0), "ill_fn_exec_add");
      cyc(vw(2'd1, 1'b0), "ill_fn_wb");
    end
    do_reset();

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d left want 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Next-generation MIPS control unit: a multi-cycle sequencer in place of pure combinational decode.
- Decodes opcode/func, then steps the datapath through FETCH/DECODE/EXEC/MEM/WB one phase per cycle.
- Supports wait-stated memory through a req/ready handshake and a parametrised multi-cycle multiply.
- Sits between the IR and the shared single-port memory, register file, ALU and PC mux.

Parameters:
- MUL_LATENCY, 3: total EXEC cycles for MUL/MADD/MADDU; must be >=1.
- ALU_CTRL_W, 6: width of alu_control.
- CNT_W, 4: width of the multiply cycle counter; must satisfy 2^CNT_W > MUL_LATENCY.

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26], sampled in DECODE
- func  in  6  IR[5:0], sampled in DECODE
- mem_ready  in  1  memory completion for the current mem_req
- branch_taken  in  1  ALU condition result, valid in EXEC
- state  out  3  current state, for debug
- pc_write  out  1  PC load strobe
- pc_src  out  2  PC source: 0=PC+4, 1=branch target, 2=jump target, 3=register (JR)
- ir_write  out  1  IR load strobe
- mem_req  out  1  memory access request
- mem_write  out  1  store qualifier on mem_req
- mem_to_reg  out  1  write-back selects memory data
- reg_write  out  1  register file write strobe
- reg_dst  out  2  destination select: 0=rt, 1=rd, 2=$31
- alu_src  out  2  ALU B source: 0=rt, 1=immediate, 2=shamt
- alu_control  out  ALU_CTRL_W  ALU operation code
- done  out  1  sticky halt indicator
- illegal  out  1  undefined instruction (optional feature only; tied 0 otherwise)

Behaviour:
- Reset: rst is asynchronous and active-high. On assertion, state=FETCH and the counter and latched decode fields clear. While rst is high, every output is 0. rst mid-operation abandons the current instruction, with no partial writes after assertion.
- Outputs are a combinational function of state plus decode fields latched in DECODE. They are stable across wait cycles.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are unreachable and must recover to FETCH.
- FETCH:
  - mem_req=1 is held until mem_ready.
  - In the mem_ready cycle: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
- DECODE (decode table in the package):
  - HALT (63) goes to HALT.
  - J: pc_write=1, pc_src=2, next FETCH.
  - JAL: additionally reg_write=1, reg_dst=2, next FETCH.
  - Any other opcode goes to EXEC.
- EXEC (drives alu_control and alu_src):
  - MUL/MADD/MADDU stay in EXEC for exactly MUL_LATENCY cycles via the counter.
  - Branch: pc_write=branch_taken, pc_src=1, next FETCH.
  - JR: pc_write=1, pc_src=3, next FETCH.
  - LW/SW go to MEM. All others go to WB.
- MEM:
  - mem_req=1; mem_write=1 for SW. Held until mem_ready.
  - SW goes to FETCH; LW goes to WB.
- WB: one cycle with reg_write=1, latched reg_dst, mem_to_reg=1 for LW. Next FETCH.
- HALT: done=1 with all other strobes 0. Absorbing until rst.
- mem_ready is ignored outside FETCH and MEM. mem_ready asserted in the same cycle as mem_req rising completes in that cycle, giving zero wait states.
- Unknown R-type func decodes as ADD. Unknown opcode is treated as a NOP: DECODE goes to FETCH with no writes.
- Cycle counts at zero wait states:
  - J/JAL: 2
  - branch/JR: 3
  - ALU ops: 4
  - SW: 4
  - LW: 5
  - MUL-class: 3+MUL_LATENCY

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode or unknown R-type func in DECODE goes to HALT with done=1 and illegal=1, both sticky until reset.
- Undefined: NOP and ADD fallbacks as above; illegal is tied 0.

Decomposition:
- Package mips_ctrl_pkg holds:
  - Opcode constants: R=0, J=2, JAL=3, BEQ=4, BNE=5, ADDI=8, ADDIU=9, SLTI=10, SEQ=11, ANDI=12, ORI=13, XORI=14, LUI=15, BGT=24, BGTE=25, BLE=26, BLEQ=27, BLEU=28, BGTU=29, LW=35, SW=43, HALT=63.
  - Func constants.
  - ALU codes: ADD=0 through SLA=15, EQ=16, NE=17, GT=18, GE=19, LEQ=20, LEU=21, GTU=22, LUI=23, JR=24.
  - The state enum.
- Sub-module mips_instr_decoder: purely combinational; maps opcode/func to class (alu/mul/load/store/branch/jump/jal/jr/halt/illegal), alu_control, alu_src and reg_dst.
- The FSM, multiply counter and latches stay in the top module.

Test Plan:
- ADD (op0 func32), mem_ready tied 1: FETCH→DECODE→EXEC→WB, 4 cycles; reg_write=1 only in WB, reg_dst=1, alu_control=0.
- LW (op35) with mem_ready delayed 2 cycles in both FETCH and MEM: mem_req held steady; 9 cycles total; WB has mem_to_reg=1.
- MUL (func30), MUL_LATENCY=3: exactly 3 EXEC cycles with alu_control=6, then WB. Repeat with MUL_LATENCY=1: 1 EXEC cycle.
- BEQ (op4): branch_taken=1 gives pc_write=1, pc_src=1 in EXEC; branch_taken=0 gives pc_write=0. Both return to FETCH; no reg_write.
- HALT (op63): done=1 from the cycle after DECODE and stays 1 for 10+ cycles with mem_req=0. rst asserted mid-MEM: outputs 0 immediately, restart in FETCH.
- Opcode 1: NOP with macro undefined; with MULTICYCLE_ILLEGAL_TRAP_EN, HALT with illegal=1.
